// File: rtl/dp_dm_regs.sv
// Minimal RISC-V debug module register file sitting behind the DMI transport.
// Decodes data0/dmcontrol/dmstatus/abstractcs/command, drives hart halt/resume
// requests and runs access-register abstract commands through a req/ack handshake.
module dp_dm_regs #(
  parameter int ABITS      = 7,
  parameter int TIMEOUT    = 255,
  parameter int DM_VERSION = 2
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             dmi_req,
  input  logic [ABITS-1:0] dmi_address,
  input  logic [31:0]      dmi_wdata,
  input  logic [1:0]       dmi_op,
  output logic [31:0]      dmi_rdata,
  output logic             dmi_busy,
  output logic             halt_req,
  output logic             resume_req,
  input  logic             halted,
  input  logic             running,
  output logic             ar_req,
  output logic             ar_write,
  output logic [15:0]      ar_regno,
  output logic [31:0]      ar_wdata,
  input  logic [31:0]      ar_rdata,
  input  logic             ar_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [ABITS-1:0] A_DATA0      = ABITS'('h04);
  localparam logic [ABITS-1:0] A_DMCONTROL  = ABITS'('h10);
  localparam logic [ABITS-1:0] A_DMSTATUS   = ABITS'('h11);
  localparam logic [ABITS-1:0] A_ABSTRACTCS = ABITS'('h16);
  localparam logic [ABITS-1:0] A_COMMAND    = ABITS'('h17);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [31:0]     data0_reg;
  logic            haltreq_reg;
  logic            ndmreset_reg;
  logic            dmactive_reg;
  logic [2:0]      cmderr_reg;
  logic            resumeack_reg;
  logic            resume_wait_reg;
  logic            resume_req_reg;
  logic            ar_write_reg;
  logic [15:0]     ar_regno_reg;
  logic [31:0]     ar_wdata_reg;
  logic [31:0]     dmi_rdata_reg;

  logic            wr, rd;
  logic            wr_data0, wr_dmcontrol, wr_abstractcs, wr_command, rd_data0;
  logic            dmactive_next;
  logic            busy;
  logic            busy_err;
  logic            cmd_start, cmd_done;
  logic            cmderr_set;
  logic [2:0]      cmderr_val;
  logic [31:0]     rdata_mux;

  assign wr            = dmi_req && (dmi_op == 2'd2);
  assign rd            = dmi_req && (dmi_op == 2'd1);
  assign wr_data0      = wr && (dmi_address == A_DATA0);
  assign wr_dmcontrol  = wr && (dmi_address == A_DMCONTROL);
  assign wr_abstractcs = wr && (dmi_address == A_ABSTRACTCS);
  assign wr_command    = wr && (dmi_address == A_COMMAND);
  assign rd_data0      = rd && (dmi_address == A_DATA0);

  // dmactive as it will be after this edge; a write of 0 deactivates the DM at
  // the same edge, so a simultaneous ar_ack loses against the abort.
  assign dmactive_next = wr_dmcontrol ? dmi_wdata[0] : dmactive_reg;
  assign busy          = (state_reg == REQ);
  assign busy_err      = busy && (wr_command || wr_abstractcs || wr_data0 || rd_data0);

  assign dmi_rdata  = dmi_rdata_reg;
  assign dmi_busy   = busy;
  assign halt_req   = haltreq_reg & dmactive_reg;
  assign resume_req = resume_req_reg;
  assign ar_req     = busy;
  assign ar_write   = ar_write_reg;
  assign ar_regno   = ar_regno_reg;
  assign ar_wdata   = ar_wdata_reg;

  // Abstract command state register.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Abstract command sequencing: command decode, ack handling and timeout.
  always_comb begin
    state_next = state_reg;
    cmd_start  = 1'b0;
    cmd_done   = 1'b0;
    cmderr_set = 1'b0;
    cmderr_val = 3'd0;
    if (!dmactive_next) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (wr_command && (cmderr_reg == 3'd0)) begin
            if (dmi_wdata[31:24] != 8'd0) begin
              cmderr_set = 1'b1;
              cmderr_val = 3'd2;
            end else if (!dmi_wdata[17]) begin
              // transfer=0: nothing to do
            end else if (!halted) begin
              cmderr_set = 1'b1;
              cmderr_val = 3'd4;
            end else begin
              cmd_start  = 1'b1;
              state_next = REQ;
            end
          end
        end
        REQ: begin
          if (ar_ack) begin
            cmd_done   = 1'b1;
            state_next = IDLE;
          end else if (cnt_reg == CW'(TIMEOUT)) begin
            cmderr_set = 1'b1;
            cmderr_val = 3'd3;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Cycles spent waiting for ar_ack; restarts on every entry to REQ.
  always_ff @(posedge tck or posedge trst) begin
    if (trst)
      cnt_reg <= '0;
    else if (cmd_start)
      cnt_reg <= '0;
    else if (busy && (cnt_reg != CW'(TIMEOUT)))
      cnt_reg <= cnt_reg + 1'b1;
  end

  // dmcontrol fields; everything but dmactive is held clear while inactive.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      dmactive_reg <= 1'b0;
      haltreq_reg  <= 1'b0;
      ndmreset_reg <= 1'b0;
    end else begin
      dmactive_reg <= dmactive_next;
      if (!dmactive_next) begin
        haltreq_reg  <= 1'b0;
        ndmreset_reg <= 1'b0;
      end else if (wr_dmcontrol) begin
        haltreq_reg  <= dmi_wdata[31];
        ndmreset_reg <= dmi_wdata[1];
      end
    end
  end

  // Resume pulse and resumeack tracking: ack on the first running cycle after the pulse.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      resume_req_reg  <= 1'b0;
      resume_wait_reg <= 1'b0;
      resumeack_reg   <= 1'b0;
    end else begin
      resume_req_reg <= wr_dmcontrol && dmi_wdata[30] && halted && dmactive_next;
      if (!dmactive_next) begin
        resume_wait_reg <= 1'b0;
        resumeack_reg   <= 1'b0;
      end else if (wr_dmcontrol && dmi_wdata[30]) begin
        resume_wait_reg <= halted;
        resumeack_reg   <= 1'b0;
      end else if (resume_wait_reg && running) begin
        resume_wait_reg <= 1'b0;
        resumeack_reg   <= 1'b1;
      end
    end
  end

  // data0: host writes when idle, hart read data on a completed read command.
  always_ff @(posedge tck or posedge trst) begin
    if (trst)
      data0_reg <= '0;
    else if (!dmactive_next)
      data0_reg <= '0;
    else if (cmd_done && !ar_write_reg)
      data0_reg <= ar_rdata;
    else if (wr_data0 && !busy)
      data0_reg <= dmi_wdata;
  end

  // cmderr: FSM errors first, then busy violations, then W1C clearing.
  always_ff @(posedge tck or posedge trst) begin
    if (trst)
      cmderr_reg <= 3'd0;
    else if (!dmactive_next)
      cmderr_reg <= 3'd0;
    else if (cmderr_set)
      cmderr_reg <= cmderr_val;
    else if (busy_err && (cmderr_reg == 3'd0))
      cmderr_reg <= 3'd1;
    else if (wr_abstractcs && !busy)
      cmderr_reg <= cmderr_reg & ~dmi_wdata[10:8];
  end

  // Latch the abstract access parameters when a command launches.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ar_write_reg <= 1'b0;
      ar_regno_reg <= '0;
      ar_wdata_reg <= '0;
    end else if (cmd_start) begin
      ar_write_reg <= dmi_wdata[16];
      ar_regno_reg <= dmi_wdata[15:0];
      ar_wdata_reg <= data0_reg;
    end
  end

  // Read data multiplexer over the register map.
  always_comb begin
    rdata_mux = '0;
    case (dmi_address)
      A_DATA0:     rdata_mux = data0_reg;
      A_DMCONTROL: rdata_mux = {haltreq_reg, 29'd0, ndmreset_reg, dmactive_reg};
      A_DMSTATUS: begin
        rdata_mux[17]  = resumeack_reg;
        rdata_mux[11]  = running;
        rdata_mux[9]   = halted;
        rdata_mux[3:0] = 4'(DM_VERSION);
      end
      A_ABSTRACTCS: begin
        rdata_mux[12]   = busy;
        rdata_mux[10:8] = cmderr_reg;
        rdata_mux[3:0]  = 4'd1;
      end
      default: rdata_mux = '0;
    endcase
  end

  // Registered read data, held until the next read.
  always_ff @(posedge tck or posedge trst) begin
    if (trst)    dmi_rdata_reg <= '0;
    else if (rd) dmi_rdata_reg <= rdata_mux;
  end

endmodule
